pipeline_hazard_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage (IF/ID/EX/MEM/WB) pipelined CPU.
- Keeps its own shadow copy of the register-destination info for the EX, MEM and WB slots. From that it generates:
  - stall and flush controls for the IF_ID, ID_EX and EX_MEM gates;
  - operand-forwarding selects for EX;
  - ID-stage regfile bypass selects;
  - saturating performance counters.
- Branch resolution stage is configurable: EX or MEM.

---
 rtl/pipeline_hazard_unit.sv | 198 +++++++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
// Hazard, forwarding and bypass controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// It keeps a shadow copy of the destination info held in the EX, MEM and WB slots.
// From that copy it derives stall/flush gate controls, EX operand forwarding selects,
// ID regfile bypass selects and saturating stall/flush counters.
// Optional feature macro: HAZARD_FORWARDING_EN.
//   Defined   : forwarding/bypass active; only load-use stalls (one cycle).
//   Undefined : selects tied to 0; any RAW hit in EX, MEM or WB stalls ID.
module pipeline_hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int BRANCH_STAGE   = 3,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rt_ID,
    input  logic                      useRs_ID,
    input  logic                      useRt_ID,
    input  logic                      regWrite_ID,
    input  logic                      memToReg_ID,
    input  logic [REG_ADDR_WIDTH-1:0] writeReg_ID,
    input  logic                      branchTaken,
    output logic                      stall_PC,
    output logic                      stall_IF_ID,
    output logic                      flush_IF_ID,
    output logic                      flush_ID_EX,
    output logic                      flush_EX_MEM,
    output logic [1:0]                forwardA_EX,
    output logic [1:0]                forwardB_EX,
    output logic                      bypassA_ID,
    output logic                      bypassB_ID,
    output logic [COUNT_WIDTH-1:0]    stallCount,
    output logic [COUNT_WIDTH-1:0]    flushCount
);

    typedef logic [REG_ADDR_WIDTH-1:0] reg_t;

    typedef struct packed {
        logic v;
        reg_t rs;
        reg_t rt;
        reg_t dst;
        logic rw;
        logic ld;
    } ex_slot_t;

    typedef struct packed {
        logic v;
        reg_t dst;
        logic rw;
        logic ld;
    } mem_slot_t;

    typedef struct packed {
        logic v;
        reg_t dst;
        logic rw;
    } wb_slot_t;

    if (BRANCH_STAGE != 2 && BRANCH_STAGE != 3) begin : g_bad_branch_stage
        $error("pipeline_hazard_unit: BRANCH_STAGE must be 2 (EX) or 3 (MEM)");
    end

    // A MEM-resolved branch has a wrong-path instruction sitting in EX, so it kills MEM too.
    localparam logic FLUSH_MEM = (BRANCH_STAGE == 3);

    ex_slot_t  ex_q,  ex_n;
    mem_slot_t mem_q, mem_n;
    wb_slot_t  wb_q,  wb_n;
    logic      stall;
    logic      hit_ex;
    logic      unused_bits;

    // A slot "writes r" only for a real, register-writing instruction; $0 is never a hazard.
    function automatic logic writes(input logic v, input logic rw, input reg_t dst, input reg_t r);
        return v & rw & (dst == r) & (r != '0);
    endfunction

    // Does the EX slot produce a source the ID instruction actually reads?
    always_comb begin
        hit_ex = (useRs_ID & writes(ex_q.v, ex_q.rw, ex_q.dst, rs_ID)) |
                 (useRt_ID & writes(ex_q.v, ex_q.rw, ex_q.dst, rt_ID));
    end

`ifdef HAZARD_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time; everything else is bypassed.
    assign stall = valid_ID & ex_q.ld & hit_ex;
`else
    logic hit_mem, hit_wb;

    // Without forwarding, any in-flight producer of a used source holds ID.
    always_comb begin
        hit_mem = (useRs_ID & writes(mem_q.v, mem_q.rw, mem_q.dst, rs_ID)) |
                  (useRt_ID & writes(mem_q.v, mem_q.rw, mem_q.dst, rt_ID));
        hit_wb  = (useRs_ID & writes(wb_q.v, wb_q.rw, wb_q.dst, rs_ID)) |
                  (useRt_ID & writes(wb_q.v, wb_q.rw, wb_q.dst, rt_ID));
    end

    assign stall = valid_ID & (hit_ex | hit_mem | hit_wb);
`endif

    // Gate controls: a taken branch outranks any simultaneous stall.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        stall_PC     = 1'b0;
        stall_IF_ID  = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        if (branchTaken) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = FLUSH_MEM;
        end else if (stall) begin
            stall_PC    = 1'b1;
            stall_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end
    end

    // Next slot contents: a bubble enters EX on flush or stall, otherwise the ID instruction.
    always_comb begin
        ex_n  = '0;
        mem_n = '{v: ex_q.v, dst: ex_q.dst, rw: ex_q.rw, ld: ex_q.ld};
        wb_n  = '{v: mem_q.v, dst: mem_q.dst, rw: mem_q.rw};
        if (branchTaken) begin
            if (FLUSH_MEM) begin
                mem_n = '0;
            end
        end else if (!stall) begin
            ex_n = '{v: valid_ID, rs: rs_ID, rt: rt_ID, dst: writeReg_ID,
                     rw: regWrite_ID, ld: memToReg_ID};
        end
    end

    // Slot registers; reset clears the whole slot so the selects read 00 right after reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all slots update together.
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_n;
            mem_q <= mem_n;
            wb_q  <= wb_n;
        end
    end

    // Performance counters: saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (branchTaken && flushCount != '1) begin
                flushCount <= flushCount + COUNT_WIDTH'(1);
            end
            if (!branchTaken && stall && stallCount != '1) begin
                stallCount <= stallCount + COUNT_WIDTH'(1);
            end
        end
    end

`ifdef HAZARD_FORWARDING_EN
    // EX operand forwarding (MEM beats WB) and ID bypass from the WB slot.
    always_comb begin
        forwardA_EX = 2'b00;
        forwardB_EX = 2'b00;
        if (writes(mem_q.v, mem_q.rw, mem_q.dst, ex_q.rs)) begin
            forwardA_EX = 2'b10;
        end else if (writes(wb_q.v, wb_q.rw, wb_q.dst, ex_q.rs)) begin
            forwardA_EX = 2'b01;
        end
        if (writes(mem_q.v, mem_q.rw, mem_q.dst, ex_q.rt)) begin
            forwardB_EX = 2'b10;
        end else if (writes(wb_q.v, wb_q.rw, wb_q.dst, ex_q.rt)) begin
            forwardB_EX = 2'b01;
        end
        bypassA_ID = valid_ID & useRs_ID & writes(wb_q.v, wb_q.rw, wb_q.dst, rs_ID);
        bypassB_ID = valid_ID & useRt_ID & writes(wb_q.v, wb_q.rw, wb_q.dst, rt_ID);
    end

    // The load flag only matters while the producer sits in EX.
    assign unused_bits = mem_q.ld;
`else
    assign forwardA_EX = 2'b00;
    assign forwardB_EX = 2'b00;
    assign bypassA_ID  = 1'b0;
    assign bypassB_ID  = 1'b0;

    // Source fields of EX and the MEM load flag have no consumer when stalling resolves all RAW hazards.
    assign unused_bits = ^{mem_q.ld, ex_q.rs, ex_q.rt};
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit
// Randomized plus directed stimulus against an instruction-level pipeline model.
// Two DUTs share inputs: index 0 = BRANCH_STAGE 3 / 16-bit counters,
// index 1 = BRANCH_STAGE 2 / 4-bit counters (exercises saturation quickly).
// Works with and without HAZARD_FORWARDING_EN defined.
module tb_pipeline_hazard_unit;

    typedef struct {
        bit valid;
        int rs;
        int rt;
        bit use_rs;
        bit use_rt;
        bit rw;
        bit ld;
        int dst;
    } instr_t;

    // One in-flight instruction as the model sees it.
    typedef struct {
        bit v;
        int rs;
        int rt;
        int dst;
        bit rw;
        bit ld;
    } slot_t;

    logic       clk;
    logic       reset;
    logic       valid_ID, useRs_ID, useRt_ID, regWrite_ID, memToReg_ID, branchTaken;
    logic [4:0] rs_ID, rt_ID, writeReg_ID;

    logic       stall_pc [2];
    logic       stall_if_id [2];
    logic       flush_if_id [2];
    logic       flush_id_ex [2];
    logic       flush_ex_mem [2];
    logic [1:0] fwd_a [2];
    logic [1:0] fwd_b [2];
    logic       byp_a [2];
    logic       byp_b [2];
    logic [15:0] scnt0, fcnt0;
    logic [3:0]  scnt1, fcnt1;

    pipeline_hazard_unit #(.REG_ADDR_WIDTH(5), .BRANCH_STAGE(3), .COUNT_WIDTH(16)) u_dut_b3 (
        .clk(clk), .reset(reset), .valid_ID(valid_ID), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .useRs_ID(useRs_ID), .useRt_ID(useRt_ID), .regWrite_ID(regWrite_ID),
        .memToReg_ID(memToReg_ID), .writeReg_ID(writeReg_ID), .branchTaken(branchTaken),
        .stall_PC(stall_pc[0]), .stall_IF_ID(stall_if_id[0]), .flush_IF_ID(flush_if_id[0]),
        .flush_ID_EX(flush_id_ex[0]), .flush_EX_MEM(flush_ex_mem[0]),
        .forwardA_EX(fwd_a[0]), .forwardB_EX(fwd_b[0]),
        .bypassA_ID(byp_a[0]), .bypassB_ID(byp_b[0]),
        .stallCount(scnt0), .flushCount(fcnt0)
    );

    pipeline_hazard_unit #(.REG_ADDR_WIDTH(5), .BRANCH_STAGE(2), .COUNT_WIDTH(4)) u_dut_b2 (
        .clk(clk), .reset(reset), .valid_ID(valid_ID), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .useRs_ID(useRs_ID), .useRt_ID(useRt_ID), .regWrite_ID(regWrite_ID),
        .memToReg_ID(memToReg_ID), .writeReg_ID(writeReg_ID), .branchTaken(branchTaken),
        .stall_PC(stall_pc[1]), .stall_IF_ID(stall_if_id[1]), .flush_IF_ID(flush_if_id[1]),
        .flush_ID_EX(flush_id_ex[1]), .flush_EX_MEM(flush_ex_mem[1]),
        .forwardA_EX(fwd_a[1]), .forwardB_EX(fwd_b[1]),
        .bypassA_ID(byp_a[1]), .bypassB_ID(byp_b[1]),
        .stallCount(scnt1), .flushCount(fcnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    instr_t cur;
    bit     br;

    // Model state per DUT: [0]=EX, [1]=MEM, [2]=WB, plus the counters.
    slot_t pipe [2][3];
    int    cnt_stall [2];
    int    cnt_flush [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int cnt_max(input int c);
        return (c == 0) ? 65535 : 15;
    endfunction

    function automatic int bstage(input int c);
        return (c == 0) ? 3 : 2;
    endfunction

    function automatic slot_t bubble();
        slot_t s = '{1'b0, 0, 0, 0, 1'b0, 1'b0};
        return s;
    endfunction

    function automatic bit writes(input slot_t s, input int r);
        return s.v && s.rw && (s.dst == r) && (r != 0);
    endfunction

    function automatic bit src_hit(input slot_t s, input instr_t i);
        return (i.use_rs && writes(s, i.rs)) || (i.use_rt && writes(s, i.rt));
    endfunction

    // Does the ID instruction have to wait (ignoring any branch)?
    function automatic bit m_stall(input int c, input instr_t i);
`ifdef HAZARD_FORWARDING_EN
        return i.valid && pipe[c][0].ld && src_hit(pipe[c][0], i);
`else
        return i.valid && (src_hit(pipe[c][0], i) || src_hit(pipe[c][1], i) ||
                           src_hit(pipe[c][2], i));
`endif
    endfunction

    function automatic int fwd_sel(input int c, input int r);
`ifdef HAZARD_FORWARDING_EN
        if (writes(pipe[c][1], r)) return 2;
        if (writes(pipe[c][2], r)) return 1;
`endif
        return 0;
    endfunction

    function automatic bit byp(input int c, input bit used, input int r);
`ifdef HAZARD_FORWARDING_EN
        return cur.valid && used && writes(pipe[c][2], r);
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare(input int c);
        string p  = (c == 0) ? "b3" : "b2";
        bit    st = m_stall(c, cur) && !br;
        check({p, "_stall_PC"},     32'(stall_pc[c]),     32'(st));
        check({p, "_stall_IF_ID"},  32'(stall_if_id[c]),  32'(st));
        check({p, "_flush_IF_ID"},  32'(flush_if_id[c]),  32'(br));
        check({p, "_flush_ID_EX"},  32'(flush_id_ex[c]),  32'(br || st));
        check({p, "_flush_EX_MEM"}, 32'(flush_ex_mem[c]), 32'(br && bstage(c) == 3));
        check({p, "_forwardA"},     32'(fwd_a[c]),        32'(fwd_sel(c, pipe[c][0].rs)));
        check({p, "_forwardB"},     32'(fwd_b[c]),        32'(fwd_sel(c, pipe[c][0].rt)));
        check({p, "_bypassA"},      32'(byp_a[c]),        32'(byp(c, cur.use_rs, cur.rs)));
        check({p, "_bypassB"},      32'(byp_b[c]),        32'(byp(c, cur.use_rt, cur.rt)));
        if (c == 0) begin
            check("b3_stallCount", 32'(scnt0), 32'(cnt_stall[0]));
            check("b3_flushCount", 32'(fcnt0), 32'(cnt_flush[0]));
        end else begin
            check("b2_stallCount", 32'(scnt1), 32'(cnt_stall[1]));
            check("b2_flushCount", 32'(fcnt1), 32'(cnt_flush[1]));
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                for (int s = 0; s < 3; s++) pipe[c][s] = bubble();
                cnt_stall[c] = 0;
                cnt_flush[c] = 0;
            end else begin
                slot_t ex  = pipe[c][0];
                slot_t mem = pipe[c][1];
                bit    st  = m_stall(c, cur);
                pipe[c][2] = mem;
                if (br) begin
                    if (cnt_flush[c] < cnt_max(c)) cnt_flush[c]++;
                    pipe[c][1] = (bstage(c) == 3) ? bubble() : ex;
                    pipe[c][0] = bubble();
                end else if (st) begin
                    if (cnt_stall[c] < cnt_max(c)) cnt_stall[c]++;
                    pipe[c][1] = ex;
                    pipe[c][0] = bubble();
                end else begin
                    pipe[c][1] = ex;
                    pipe[c][0] = '{cur.valid, cur.rs, cur.rt, cur.dst, cur.rw, cur.ld};
                end
            end
        end
    endtask

    task automatic drive(input instr_t i, input bit b);
        cur         = i;
        br          = b;
        valid_ID    = i.valid;
        rs_ID       = 5'(i.rs);
        rt_ID       = 5'(i.rt);
        useRs_ID    = i.use_rs;
        useRt_ID    = i.use_rt;
        regWrite_ID = i.rw;
        memToReg_ID = i.ld;
        writeReg_ID = 5'(i.dst);
        branchTaken = b;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic tick(output bit stalled);
        #2;
        stalled = !br && m_stall(0, cur);
        if (!reset) begin
            compare(0);
            compare(1);
        end
        model_edge();
        @(negedge clk);
    endtask

    // Present one instruction in ID, holding it there while the pipeline stalls it.
    task automatic run_instr(input instr_t i, input bit b);
        bit stalled;
        int guard = 0;
        do begin
            drive(i, b);
            tick(stalled);
            guard++;
        end while (stalled && guard < 8);
        if (stalled) check("hold_bound", 32'(guard), 32'(4));
    endtask

    function automatic instr_t mk(input bit valid, input int rs, input int rt, input bit use_rs,
                                  input bit use_rt, input bit rw, input bit ld, input int dst);
        instr_t i = '{valid, rs, rt, use_rs, use_rt, rw, ld, dst};
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid  = ($urandom_range(7) != 0);
        i.rs     = ($urandom_range(15) == 0) ? 31 : int'($urandom_range(3));
        i.rt     = int'($urandom_range(3));
        i.dst    = ($urandom_range(15) == 0) ? 31 : int'($urandom_range(3));
        i.use_rs = ($urandom_range(1) == 1);
        i.use_rt = ($urandom_range(1) == 1);
        i.rw     = ($urandom_range(3) != 0);
        i.ld     = i.rw && ($urandom_range(2) == 0);
        return i;
    endfunction

    task automatic do_reset(input int n);
        bit s;
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        repeat (n) tick(s);
        reset = 1'b0;
    endtask

    instr_t nop, lw5, add_rt5;

    initial begin
        bit s;
        nop     = mk(1, 0, 0, 0, 0, 0, 0, 0);
        lw5     = mk(1, 1, 0, 1, 0, 1, 1, 5);
        add_rt5 = mk(1, 2, 5, 1, 1, 0, 0, 0);
        reset = 1'b1;
        drive(nop, 1'b0);
        @(negedge clk);
        do_reset(2);
        check("rst_stallCount", 32'(scnt0), 32'd0);
        check("rst_flushCount", 32'(fcnt0), 32'd0);

        // ALU-ALU back to back, then with a one-instruction gap.
        run_instr(mk(1, 1, 2, 1, 1, 1, 0, 3), 1'b0);
        run_instr(mk(1, 3, 1, 1, 1, 1, 0, 7), 1'b0);
        run_instr(nop, 1'b0);
        run_instr(nop, 1'b0);
        run_instr(mk(1, 1, 2, 1, 1, 1, 0, 3), 1'b0);
        run_instr(nop, 1'b0);
        run_instr(mk(1, 3, 1, 1, 1, 1, 0, 7), 1'b0);
        repeat (3) run_instr(nop, 1'b0);

        // Load-use, then register zero never hazards.
        run_instr(lw5, 1'b0);
        run_instr(add_rt5, 1'b0);
        repeat (3) run_instr(nop, 1'b0);
        run_instr(mk(1, 1, 0, 1, 0, 1, 1, 0), 1'b0);
        run_instr(mk(1, 0, 0, 1, 1, 1, 0, 2), 1'b0);
        repeat (3) run_instr(nop, 1'b0);

        // Branch together with a load-use stall.
        do_reset(1);
        run_instr(lw5, 1'b0);
        drive(add_rt5, 1'b1);
        tick(s);
        check("br_flushCount", 32'(fcnt0), 32'd1);
        check("br_stallCount", 32'(scnt0), 32'd0);
        repeat (3) run_instr(nop, 1'b0);

        // Reset during a load-use stall.
        run_instr(lw5, 1'b0);
        drive(add_rt5, 1'b0);
        tick(s);
        reset = 1'b1;
        tick(s);
        reset = 1'b0;
        check("rstmid_stall_PC", 32'(stall_pc[0]), 32'd0);
        check("rstmid_flush_ID_EX", 32'(flush_id_ex[0]), 32'd0);
        check("rstmid_stallCount", 32'(scnt0), 32'd0);
        run_instr(add_rt5, 1'b0);

        // Single RAW on the preceding ALU instruction.
        do_reset(1);
        run_instr(mk(1, 0, 0, 0, 0, 1, 0, 4), 1'b0);
        run_instr(mk(1, 4, 0, 1, 0, 1, 0, 6), 1'b0);
`ifdef HAZARD_FORWARDING_EN
        check("raw_stallCount", 32'(scnt0), 32'd0);
`else
        check("raw_stallCount", 32'(scnt0), 32'd3);
`endif

        // Counter saturation on the 4-bit instance.
        do_reset(1);
        for (int k = 0; k < 20; k++) begin
            run_instr(mk(1, 0, 0, 0, 0, 1, 1, 5), 1'b0);
            run_instr(add_rt5, 1'b0);
        end
        check("sat_b2_stallCount", 32'(scnt1), 32'd15);
`ifdef HAZARD_FORWARDING_EN
        check("sat_b3_stallCount", 32'(scnt0), 32'd20);
`else
        check("sat_b3_stallCount", 32'(scnt0), 32'd60);
`endif
        // Flush counter saturation on the 4-bit instance.
        repeat (18) run_instr(nop, 1'b1);
        check("sat_b2_flushCount", 32'(fcnt1), 32'd15);

        // Random traffic with occasional branches and resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(99) == 0) do_reset(1);
            run_instr(rand_instr(), ($urandom_range(9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
